// File: rtl/decode_pkg.sv
// Shared types and constants for the two-wide RV32I R-type decode stage.
package decode_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  // ALU operation encoding; ALU_INV marks an empty slot.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_INV  = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    PAIR  = 2'd0,
    SPLIT = 2'd1,
    DONE  = 2'd2
  } dec_state_t;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    alu_op_t         alu_op;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, alu_op: ALU_INV};

endpackage

// File: rtl/dual_issue_decode_if.sv
// Fetch-to-decode bundle: instruction pair in, stall and two issue slots out.
interface dual_issue_decode_if;
  import decode_pkg::*;

  logic [XLEN-1:0] instr1;
  logic [XLEN-1:0] instr2;
  logic            fetch_finish;
  logic            stall;
  logic            s0_valid;
  logic [REGW-1:0] s0_rd;
  logic [REGW-1:0] s0_rs1;
  logic [REGW-1:0] s0_rs2;
  alu_op_t         s0_alu_op;
  logic            s1_valid;
  logic [REGW-1:0] s1_rd;
  logic [REGW-1:0] s1_rs1;
  logic [REGW-1:0] s1_rs2;
  alu_op_t         s1_alu_op;
  logic            illegal;
  logic            done;

  // Fetch side
  modport master (
    output instr1, instr2, fetch_finish,
    input  stall, s0_valid, s0_rd, s0_rs1, s0_rs2, s0_alu_op,
    input  s1_valid, s1_rd, s1_rs1, s1_rs2, s1_alu_op, illegal, done
  );

  // Decode side
  modport slave (
    input  instr1, instr2, fetch_finish,
    output stall, s0_valid, s0_rd, s0_rs1, s0_rs2, s0_alu_op,
    output s1_valid, s1_rd, s1_rs1, s1_rs2, s1_alu_op, illegal, done
  );

endinterface

// File: rtl/rtype_decoder.sv
// Combinational single-word RV32I R-type decoder.
module rtype_decoder
  import decode_pkg::*;
(
  input  logic [XLEN-1:0] word,
  output slot_t           slot,
  output logic            illegal
);

  logic [6:0] opcode_s;
  logic [6:0] funct7_s;
  logic [2:0] funct3_s;
  alu_op_t    op_s;

  assign opcode_s = word[6:0];
  assign funct3_s = word[14:12];
  assign funct7_s = word[31:25];

  // Map {funct7, funct3} onto the ALU op; unsupported combinations yield ALU_INV
  always_comb begin
    op_s = ALU_INV;
    case ({funct7_s, funct3_s})
      {7'h00, 3'h0}: op_s = ALU_ADD;
      {7'h20, 3'h0}: op_s = ALU_SUB;
      {7'h00, 3'h1}: op_s = ALU_SLL;
      {7'h00, 3'h2}: op_s = ALU_SLT;
      {7'h00, 3'h3}: op_s = ALU_SLTU;
      {7'h00, 3'h4}: op_s = ALU_XOR;
      {7'h00, 3'h5}: op_s = ALU_SRL;
      {7'h20, 3'h5}: op_s = ALU_SRA;
      {7'h00, 3'h6}: op_s = ALU_OR;
      {7'h00, 3'h7}: op_s = ALU_AND;
      default:       op_s = ALU_INV;
    endcase
  end

  // Build the slot: bubbles are silent, anything else not R-type is flagged
  always_comb begin
    slot    = SLOT_EMPTY;
    illegal = 1'b0;
    if (word == {XLEN{1'b0}}) begin
      slot    = SLOT_EMPTY;
      illegal = 1'b0;
    end else if ((opcode_s != OPC_RTYPE) || (op_s == ALU_INV)) begin
      slot    = SLOT_EMPTY;
      illegal = 1'b1;
    end else begin
      slot.valid  = 1'b1;
      slot.rd     = word[11:7];
      slot.rs1    = word[19:15];
      slot.rs2    = word[24:20];
      slot.alu_op = op_s;
      illegal     = 1'b0;
    end
  end

endmodule

// File: rtl/dual_issue_decode.sv
// Two-wide decode stage: issues independent pairs together, splits dependent
// pairs over two cycles while stalling fetch, and latches a sticky done.
module dual_issue_decode
  import decode_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  dual_issue_decode_if.slave  bus
);

  slot_t      dec1_s;
  slot_t      dec2_s;
  logic       ill1_s;
  logic       ill2_s;
  logic       hazard_s;
  logic       stall_s;

  dec_state_t state_r;
  slot_t      hold_r;
  slot_t      slot0_r;
  slot_t      slot1_r;
  logic       illegal_r;
  logic       done_r;

  rtype_decoder u_dec1 (.word(bus.instr1), .slot(dec1_s), .illegal(ill1_s));
  rtype_decoder u_dec2 (.word(bus.instr2), .slot(dec2_s), .illegal(ill2_s));

  // RAW or WAW against a non-zero destination of the older instruction
  assign hazard_s = dec1_s.valid && dec2_s.valid && (dec1_s.rd != 5'd0) &&
                    ((dec2_s.rs1 == dec1_s.rd) || (dec2_s.rs2 == dec1_s.rd) ||
                     (dec2_s.rd == dec1_s.rd));

  // Stall fetch only in the cycle a hazardous pair is first seen
  always_comb begin
    if (rst) begin
      stall_s = 1'b0;
    end else if ((state_r == PAIR) && hazard_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Decode FSM with registered slot, illegal and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= PAIR;
      hold_r    <= SLOT_EMPTY;
      slot0_r   <= SLOT_EMPTY;
      slot1_r   <= SLOT_EMPTY;
      illegal_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        PAIR: begin
          slot0_r <= dec1_s;
          if (hazard_s) begin
            slot1_r   <= SLOT_EMPTY;
            hold_r    <= dec2_s;
            illegal_r <= 1'b0;
            state_r   <= SPLIT;
          end else begin
            slot1_r   <= dec2_s;
            hold_r    <= SLOT_EMPTY;
            illegal_r <= ill1_s | ill2_s;
            if (bus.fetch_finish) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= PAIR;
            end
          end
        end
        SPLIT: begin
          slot0_r   <= hold_r;
          slot1_r   <= SLOT_EMPTY;
          hold_r    <= SLOT_EMPTY;
          illegal_r <= 1'b0;
          if (bus.fetch_finish) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= PAIR;
          end
        end
        DONE: begin
          slot0_r   <= SLOT_EMPTY;
          slot1_r   <= SLOT_EMPTY;
          hold_r    <= SLOT_EMPTY;
          illegal_r <= 1'b0;
          done_r    <= 1'b1;
          state_r   <= DONE;
        end
        default: begin
          slot0_r   <= SLOT_EMPTY;
          slot1_r   <= SLOT_EMPTY;
          hold_r    <= SLOT_EMPTY;
          illegal_r <= 1'b0;
          done_r    <= 1'b0;
          state_r   <= PAIR;
        end
      endcase
    end
  end

  assign bus.stall     = stall_s;
  assign bus.s0_valid  = slot0_r.valid;
  assign bus.s0_rd     = slot0_r.rd;
  assign bus.s0_rs1    = slot0_r.rs1;
  assign bus.s0_rs2    = slot0_r.rs2;
  assign bus.s0_alu_op = slot0_r.alu_op;
  assign bus.s1_valid  = slot1_r.valid;
  assign bus.s1_rd     = slot1_r.rd;
  assign bus.s1_rs1    = slot1_r.rs1;
  assign bus.s1_rs2    = slot1_r.rs2;
  assign bus.s1_alu_op = slot1_r.alu_op;
  assign bus.illegal   = illegal_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_dual_issue_decode.sv
// Self-checking bench for dual_issue_decode: directed cases plus random pairs
// against a queue-based reference model of the decode stage.
module tb_dual_issue_decode;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst;

  dual_issue_decode_if bus ();

  dual_issue_decode dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit       ill;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [3:0] op;
  } mslot_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] held_q[$];
  bit          m_done = 1'b0;
  int          base_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [31:0] last1 = 32'h0;
  logic [31:0] last2 = 32'h0;

  localparam logic [31:0] ADD_1_2_3 = 32'h003100B3;
  localparam logic [31:0] OR_6_7_8  = 32'h0083E333;
  localparam logic [31:0] SUB_4_1_5 = 32'h40508233;

  // Reference decode of one word from the ISA field rules
  function automatic mslot_t mdec(input logic [31:0] w);
    mslot_t r;
    int     op;
    r = '{valid: 1'b0, ill: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, op: 4'hF};
    if (w == 32'h0) return r;
    op = -1;
    if (w[6:0] == 7'h33) begin
      if (w[31:25] == 7'h00) op = base_op[w[14:12]];
      else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) op = 1;
      else if (w[31:25] == 7'h20 && w[14:12] == 3'd5) op = 7;
    end
    if (op < 0) begin
      r.ill = 1'b1;
      return r;
    end
    r.valid = 1'b1;
    r.rd    = w[11:7];
    r.rs1   = w[19:15];
    r.rs2   = w[24:20];
    r.op    = 4'(op);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [3:0] op, input mslot_t e);
    chk({tag, "_valid"}, 32'(v), 32'(e.valid));
    chk({tag, "_alu_op"}, 32'(op), 32'(e.op));
    if (e.valid) begin
      chk({tag, "_rd"}, 32'(rd), 32'(e.rd));
      chk({tag, "_rs1"}, 32'(rs1), 32'(e.rs1));
      chk({tag, "_rs2"}, 32'(rs2), 32'(e.rs2));
    end
  endtask

  // One fetch cycle: drive on negedge, check stall, then check registered outputs
  task automatic cycle(input logic [31:0] i1, input logic [31:0] i2,
                       input logic ff, input logic r);
    mslot_t d1, d2, e0, e1;
    logic   e_ill, e_stall, hz;
    @(negedge clk);
    rst = r;
    bus.instr1 = i1;
    bus.instr2 = i2;
    bus.fetch_finish = ff;
    last1 = i1;
    last2 = i2;
    #1;
    d1 = mdec(i1);
    d2 = mdec(i2);
    hz = d1.valid && d2.valid && (d1.rd != 5'd0) &&
         (d2.rs1 == d1.rd || d2.rs2 == d1.rd || d2.rd == d1.rd);
    e_stall = !r && !m_done && (held_q.size() == 0) && hz;
    chk("stall", 32'(bus.stall), 32'(e_stall));
    e0 = mdec(32'h0);
    e1 = mdec(32'h0);
    e_ill = 1'b0;
    if (r) begin
      held_q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      e_ill = 1'b0;
    end else if (held_q.size() != 0) begin
      e0 = mdec(held_q.pop_front());
      if (ff) m_done = 1'b1;
    end else if (hz) begin
      e0 = d1;
      held_q.push_back(i2);
    end else begin
      e0 = d1;
      e1 = d2;
      e_ill = d1.ill | d2.ill;
      if (ff) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_slot("s0", bus.s0_valid, bus.s0_rd, bus.s0_rs1, bus.s0_rs2, bus.s0_alu_op, e0);
    chk_slot("s1", bus.s1_valid, bus.s1_rd, bus.s1_rs1, bus.s1_rs2, bus.s1_alu_op, e1);
    chk("illegal", 32'(bus.illegal), 32'(e_ill));
    chk("done", 32'(bus.done), 32'(m_done));
  endtask

  function automatic logic [31:0] rand_word();
    int          k, sel;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h0;
    if (k == 1) return {$urandom_range(0, 32'h01FF_FFFF), 7'h13};
    if (k == 2) return {7'h01, 5'(($urandom_range(0, 7))), 5'd2, 3'd0, 5'd3, 7'h33};
    sel = $urandom_range(0, 9);
    if (sel < 8) begin
      f7 = 7'h00;
      f3 = 3'(sel);
    end else if (sel == 8) begin
      f7 = 7'h20;
      f3 = 3'd0;
    end else begin
      f7 = 7'h20;
      f3 = 3'd5;
    end
    w = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
         5'($urandom_range(0, 7)), 7'h33};
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    bus.instr1 = 32'h0;
    bus.instr2 = 32'h0;
    bus.fetch_finish = 1'b0;

    // Reset state
    cycle(32'h0, 32'h0, 1'b0, 1'b1);
    cycle(ADD_1_2_3, OR_6_7_8, 1'b0, 1'b1);

    // Independent pair, then RAW pair split over two cycles, then pair issue again
    cycle(ADD_1_2_3, OR_6_7_8, 1'b0, 1'b0);
    cycle(ADD_1_2_3, SUB_4_1_5, 1'b0, 1'b0);
    cycle(ADD_1_2_3, SUB_4_1_5, 1'b0, 1'b0);
    cycle(ADD_1_2_3, OR_6_7_8, 1'b0, 1'b0);

    // Bubble in instr1, illegal words, WAW, and rd = x0 which never hazards
    cycle(32'h0, OR_6_7_8, 1'b0, 1'b0);
    cycle(32'h00000013, OR_6_7_8, 1'b0, 1'b0);
    cycle(ADD_1_2_3, 32'h60000033, 1'b0, 1'b0);
    cycle(32'h40311033, OR_6_7_8, 1'b0, 1'b0);
    cycle(ADD_1_2_3, 32'h0083E0B3, 1'b0, 1'b0);
    cycle(ADD_1_2_3, 32'h0083E0B3, 1'b0, 1'b0);
    cycle(32'h00310033, 32'h00000233, 1'b0, 1'b0);

    // Reset during SPLIT discards the held SUB
    cycle(ADD_1_2_3, SUB_4_1_5, 1'b0, 1'b0);
    cycle(ADD_1_2_3, SUB_4_1_5, 1'b0, 1'b1);
    cycle(32'h0, 32'h0, 1'b0, 1'b0);
    cycle(ADD_1_2_3, OR_6_7_8, 1'b0, 1'b0);

    // Random pairs; fetch holds its pair whenever a split is pending
    for (int i = 0; i < 400; i++) begin
      if (held_q.size() != 0) cycle(last1, last2, 1'b0, 1'b0);
      else cycle(rand_word(), rand_word(), 1'b0, 1'b0);
    end
    if (held_q.size() != 0) cycle(last1, last2, 1'b0, 1'b0);

    // Finish together with a RAW pair: split completes, then done sticks
    cycle(32'h0, 32'h0, 1'b0, 1'b1);
    cycle(ADD_1_2_3, SUB_4_1_5, 1'b1, 1'b0);
    cycle(ADD_1_2_3, SUB_4_1_5, 1'b1, 1'b0);
    cycle(ADD_1_2_3, SUB_4_1_5, 1'b1, 1'b0);
    cycle(ADD_1_2_3, OR_6_7_8, 1'b0, 1'b0);
    cycle(32'h00000013, 32'h0, 1'b0, 1'b0);

    // Plain finish from PAIR issues the final pair alongside done
    cycle(32'h0, 32'h0, 1'b0, 1'b1);
    cycle(ADD_1_2_3, OR_6_7_8, 1'b1, 1'b0);
    cycle(ADD_1_2_3, OR_6_7_8, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_decode.md
Name: dual_issue_decode

Overview:
- Decode stage directly downstream of the two-wide fetch stage.
- Consumes an instruction pair (instr1, instr2) plus the fetch finish flag every cycle, and decodes RV32I R-type instructions into two issue slots.
- Detects intra-pair hazards. On a hazard it splits the pair over two cycles and raises stall so fetch holds its pair.
- Drives a sticky done once fetch has finished and nothing is left pending.

Parameters:
- XLEN, 32, instruction width.
- REGW, 5, register index width.

Ports:
- clk  in  1  clock. Decode registers on posedge; fetch updates on negedge.
- rst  in  1  synchronous, active-high reset.
- instr1  in  XLEN  older instruction of the pair. 32'h0 = bubble.
- instr2  in  XLEN  younger instruction of the pair. 32'h0 = bubble.
- fetch_finish  in  1  fetch has run out of instructions.
- stall  out  1  combinational; fetch must hold instr1/instr2 and its pc next cycle.
- s0_valid, s1_valid  out  1 each  slot carries a legal R-type instruction.
- s0_rd, s0_rs1, s0_rs2, s1_rd, s1_rs1, s1_rs2  out  REGW each  decoded register indices.
- s0_alu_op, s1_alu_op  out  4 each  alu_op_t.
- illegal  out  1  a non-zero, non-R-type word was dropped this cycle.
- done  out  1  sticky end-of-program flag.

Behaviour:
- Reset: rst sampled at posedge. All slot outputs, illegal and done go to 0, state goes to PAIR, and the hold register is cleared. stall is 0 while rst is high. Reset wins over every other event, including mid-SPLIT; a pending held instruction is discarded.
- Latency: slot outputs are registered, 1 cycle after the inputs are sampled.
- Decode, for a word w:
  - 32'h0: slot invalid, illegal not raised.
  - opcode != 7'b0110011: slot invalid, illegal = 1 for one cycle.
  - Otherwise: rd = w[11:7], rs1 = w[19:15], rs2 = w[24:20]. alu_op comes from {funct7[5], funct3}.
  - funct7 not 0x00 or 0x20, or the pair (0x20, funct3 not in {0, 5}): treated as illegal.
- Hazard, evaluated only when both words are legal R-type and instr1.rd != 0:
  - RAW: instr2.rs1 == instr1.rd or instr2.rs2 == instr1.rd.
  - WAW: instr2.rd == instr1.rd.
- FSM:
  - PAIR, no hazard: slot0 <= instr1, slot1 <= instr2, stay in PAIR.
  - PAIR, hazard: stall = 1 this cycle. slot0 <= instr1, slot1 invalid, hold <= instr2, go to SPLIT.
  - SPLIT: inputs are ignored. slot0 <= hold, slot1 invalid, stall = 0, return to PAIR.
  - Any state, with fetch_finish = 1 sampled, no pending hold, and the state is not going to SPLIT: go to DONE.
  - DONE: done = 1 from the next cycle, slots invalid, stall = 0. Stays in DONE until rst.
- Simultaneous hazard and fetch_finish: SPLIT completes first, then DONE.
- Bubble in instr1 with a valid instr2: instr2 issues in slot1. No compaction into slot0.
- alu_op width rule: the encoding fits in 4 bits. ALU_INV = 4'hF, and it is driven whenever the slot is invalid.

Decomposition:
- Shared package decode_pkg:
  - alu_op_t: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, INV=F.
  - OPC_RTYPE constant.
  - dec_state_t {PAIR, SPLIT, DONE}.
  - slot_t struct {valid, rd, rs1, rs2, alu_op}.
- Sub-module rtype_decoder: a purely combinational word -> slot_t + illegal. Instantiated twice.

Test Plan:
- Independent pair: 0x003100B3 (add x1,x2,x3) and 0x0083E333 (or x6,x7,x8).
  - stall stays 0.
  - Next cycle: s0 = {1, rd 1, rs1 2, rs2 3, ADD} and s1 = {1, rd 6, rs1 7, rs2 8, OR}.
- RAW pair: 0x003100B3 and 0x40508233 (sub x4,x1,x5).
  - stall = 1 in the first cycle.
  - Cycle +1: s0 = ADD rd 1, s1_valid = 0.
  - Cycle +2: s0 = SUB rd 4, rs1 1, rs2 5.
  - Cycle +3: back to pair issue.
- Bubbles: 0x00000000 and 0x0083E333 -> s0_valid = 0, s1 = OR, illegal = 0.
- Illegal: 0x00000013 (addi) in instr1 -> s0_valid = 0, illegal = 1 for one cycle.
- Finish: fetch_finish = 1 together with a RAW pair -> the split completes, then done = 1 on the cycle after SPLIT and stays high.
- Reset mid-SPLIT: assert rst in the SPLIT cycle -> next cycle all slots invalid, done = 0, state PAIR, and the held SUB is never issued.
